// File: rtl/cnt_input_conditioner.sv
// Conditions a raw bouncing push-button level into a clean count enable for the
// downstream analysis FSM: 2-flop synchroniser, debounce FSM, level/pulse output stage.
module cnt_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_MODE      = 1,
    parameter int unsigned PRESS_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_raw,
    output logic               cnt,
    output logic               btn_stable,
    output logic [PRESS_W-1:0] press_count
);

    localparam int unsigned CTR_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RISE = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_FALL = 2'd3;

    logic               sync_s1;
    logic               sync_s2;
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CTR_W-1:0]   ctr;
    logic [CTR_W-1:0]   ctr_nxt;
    logic               stable_nxt;
    logic               cnt_nxt;
    logic               press_accept;
    logic [PRESS_W-1:0] press_nxt;

    // Two-flop synchroniser; only sync_s2 is allowed to reach the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            sync_s1 <= btn_raw;
            sync_s2 <= sync_s1;
        end
    end

    // State and registered outputs; reset wins over any pending transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            ctr         <= '0;
            btn_stable  <= 1'b0;
            cnt         <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nxt;
            ctr         <= ctr_nxt;
            btn_stable  <= stable_nxt;
            cnt         <= cnt_nxt;
            press_count <= press_nxt;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES agreeing samples
    // following the first opposite sample; any sample back at the old level aborts.
    always_comb begin
        state_nxt    = state;
        ctr_nxt      = ctr;
        stable_nxt   = btn_stable;
        press_nxt    = press_count;
        press_accept = 1'b0;

        case (state)
            ST_IDLE: begin
                if (sync_s2) begin
                    state_nxt = ST_RISE;
                    ctr_nxt   = '0;
                end
            end
            ST_RISE: begin
                if (!sync_s2) begin
                    state_nxt = ST_IDLE;
                end else if (ctr == CTR_LAST) begin
                    state_nxt    = ST_HIGH;
                    stable_nxt   = 1'b1;
                    press_nxt    = press_count + PRESS_W'(1);
                    press_accept = 1'b1;
                end else begin
                    ctr_nxt = ctr + CTR_W'(1);
                end
            end
            ST_HIGH: begin
                if (!sync_s2) begin
                    state_nxt = ST_FALL;
                    ctr_nxt   = '0;
                end
            end
            ST_FALL: begin
                if (sync_s2) begin
                    state_nxt = ST_HIGH;
                end else if (ctr == CTR_LAST) begin
                    state_nxt  = ST_IDLE;
                    stable_nxt = 1'b0;
                end else begin
                    ctr_nxt = ctr + CTR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ctr_nxt   = '0;
            end
        endcase

        cnt_nxt = (PULSE_MODE != 0) ? press_accept : stable_nxt;
    end

endmodule

// File: tb/tb_cnt_input_conditioner.sv
// Scoreboard bench: a run-length debounce model predicts every cycle's outputs of a
// pulse-mode instance (D=4, 8-bit count) and a level-mode instance (D=1, 2-bit count).
module tb_cnt_input_conditioner;

    typedef struct packed {
        logic       c0;
        logic       s0;
        logic [7:0] p0;
        logic       c1;
        logic       s1;
        logic [1:0] p1;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       btn_raw;
    logic       cnt_a, stable_a;
    logic [7:0] count_a;
    logic       cnt_b, stable_b;
    logic [1:0] count_b;

    int checks;
    int errors;
    bit started;
    exp_t sb_q[$];

    // Reference model state, one slot per instance
    int md[2]    = '{4, 1};
    int mmode[2] = '{1, 0};
    int mmod[2]  = '{256, 4};
    int m_s1[2], m_s2[2], m_st[2], m_run[2], m_c[2], m_pc[2];

    cnt_input_conditioner #(.DEBOUNCE_CYCLES(4), .PULSE_MODE(1), .PRESS_W(8)) dut_a (
        .clock(clock), .reset(reset), .btn_raw(btn_raw),
        .cnt(cnt_a), .btn_stable(stable_a), .press_count(count_a)
    );

    cnt_input_conditioner #(.DEBOUNCE_CYCLES(1), .PULSE_MODE(0), .PRESS_W(2)) dut_b (
        .clock(clock), .reset(reset), .btn_raw(btn_raw),
        .cnt(cnt_b), .btn_stable(stable_b), .press_count(count_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Level flips once the synchronised input has disagreed with it for D+1 samples in a row.
    task automatic model_step(input int i, input logic r, input logic b);
        int pulse;
        if (r) begin
            m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0; m_c[i] = 0; m_pc[i] = 0;
        end else begin
            pulse = 0;
            if (m_s2[i] != m_st[i]) begin
                m_run[i]++;
                if (m_run[i] == md[i] + 1) begin
                    m_st[i]  = 1 - m_st[i];
                    m_run[i] = 0;
                    if (m_st[i] == 1) begin
                        m_pc[i] = (m_pc[i] + 1) % mmod[i];
                        pulse   = 1;
                    end
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(b);
            m_c[i]  = (mmode[i] != 0) ? pulse : m_st[i];
        end
    endtask

    task automatic cyc(input logic r, input logic b);
        exp_t e;
        @(negedge clock);
        reset   = r;
        btn_raw = b;
        for (int i = 0; i < 2; i++) model_step(i, r, b);
        e.c0 = 1'(m_c[0]);
        e.s0 = 1'(m_st[0]);
        e.p0 = 8'(m_pc[0]);
        e.c1 = 1'(m_c[1]);
        e.s1 = 1'(m_st[1]);
        e.p1 = 2'(m_pc[1]);
        sb_q.push_back(e);
        started = 1'b1;
    endtask

    // Monitor: every cycle the DUTs present a result, compared against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (started) begin
                if (sb_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("cnt_a",      int'(cnt_a),    int'(e.c0));
                    chk("stable_a",   int'(stable_a), int'(e.s0));
                    chk("count_a",    int'(count_a),  int'(e.p0));
                    chk("cnt_b",      int'(cnt_b),    int'(e.c1));
                    chk("stable_b",   int'(stable_b), int'(e.s1));
                    chk("count_b",    int'(count_b),  int'(e.p1));
                end
            end
        end
    end

    initial begin
        logic lvl;
        checks  = 0;
        errors  = 0;
        started = 1'b0;
        reset   = 1'b1;
        btn_raw = 1'b0;
        for (int i = 0; i < 2; i++) model_step(i, 1'b1, 1'b0);

        // Reset with random raw input, then quiet low
        repeat (3) cyc(1'b1, 1'($urandom_range(0, 1)));
        repeat (20) cyc(1'b0, 1'b0);

        // Single clean press and release
        repeat (14) cyc(1'b0, 1'b1);
        repeat (14) cyc(1'b0, 1'b0);

        // Bounce that never qualifies on the D=4 instance
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'((i % 2) == 0));
        repeat (10) cyc(1'b0, 1'b0);

        // Five clean presses
        repeat (5) begin
            repeat (8) cyc(1'b0, 1'b1);
            repeat (8) cyc(1'b0, 1'b0);
        end

        // Reset lands mid-debounce with the button still held; it must re-qualify afterwards
        repeat (5) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (12) cyc(1'b0, 1'b1);
        repeat (12) cyc(1'b0, 1'b0);

        // Random level runs with occasional reset
        lvl = 1'b0;
        repeat (80) begin
            lvl = ~lvl;
            repeat ($urandom_range(1, 8)) cyc(1'($urandom_range(0, 29) == 0), lvl);
        end
        repeat (12) cyc(1'b0, 1'b0);

        // Enough presses to wrap the 8-bit counter
        repeat (260) begin
            repeat (6) cyc(1'b0, 1'b1);
            repeat (6) cyc(1'b0, 1'b0);
        end

        @(posedge clock);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
